tidc_l2_mem_responder: RTL

Synthesisable-style L2 backing-store model that sits directly downstream of the TIDC coherence manager and consumes its l2_cmd_* stream. It queues commands, services them in order after a fixed latency, updates a line-granular memory, and returns one l2_response_* pulse per command. It adds l2_cmd_ready backpressure and error reporting. Used as the L2 endpoint in 1-L1 and 2-L1 coherence benches and in FPGA bring-up.

---
 rtl/tidc_l2_mem_responder_pkg.sv | 34 +++
 rtl/tidc_l2_mem_responder_fifo.sv | 56 +++++
 rtl/tidc_l2_mem_responder.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/tidc_l2_mem_responder_pkg.sv
// Shared TIDC L2 command encodings, line geometry and responder types.
package tidc_l2_mem_responder_pkg;

  localparam int LINE_BITS      = 512;
  localparam int LINE_SIZE_LOG2 = 6;

  localparam logic [2:0] L2_CMD_READ       = 3'd1;
  localparam logic [2:0] L2_CMD_WRITE      = 3'd2;
  localparam logic [2:0] L2_CMD_WRITE_BACK = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } resp_state_e;

  typedef struct packed {
    logic [2:0]           cmd_type;
    logic [63:0]          addr;
    logic [LINE_BITS-1:0] data;
    logic [3:0]           size;
    logic                 dirty;
  } l2_cmd_t;

  function automatic logic cmd_type_known(input logic [2:0] t);
    logic known;
    case (t)
      L2_CMD_READ, L2_CMD_WRITE, L2_CMD_WRITE_BACK: known = 1'b1;
      default:                                      known = 1'b0;
    endcase
    return known;
  endfunction

endpackage

// File: rtl/tidc_l2_mem_responder_fifo.sv
// tidc_sync_fifo: single-clock FIFO with registered occupancy, reusable by TIDC queues.
module tidc_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] store_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      level_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (level_r == LVL_FULL);
  assign empty  = (level_r == {(AW+1){1'b0}});
  assign level  = level_r;
  assign head   = store_r[rd_ptr_r];
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {(AW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + (AW+1)'(1);
        2'b01:   level_r <= level_r - (AW+1)'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Entry storage; contents are don't-care until pushed.
  always_ff @(posedge clk) begin
    if (push_s) store_r[wr_ptr_r] <= push_data;
  end

endmodule

// File: rtl/tidc_l2_mem_responder.sv
// L2 backing-store endpoint: queues l2_cmd_* commands, executes them in order after
// LATENCY cycles against a line memory and returns one response pulse per command.
module tidc_l2_mem_responder
  import tidc_l2_mem_responder_pkg::*;
#(
  parameter int MEM_LINES = 1024,
  parameter int QDEPTH    = 4,
  parameter int LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 l2_cmd_valid,
  output logic                 l2_cmd_ready,
  input  logic [2:0]           l2_cmd_type,
  input  logic [63:0]          l2_cmd_addr,
  input  logic [LINE_BITS-1:0] l2_cmd_data,
  input  logic [3:0]           l2_cmd_size,
  input  logic                 l2_cmd_dirty,
  output logic                 l2_response_valid,
  output logic [LINE_BITS-1:0] l2_response_data,
  output logic                 l2_response_error,
  output logic [31:0]          rd_count,
  output logic [31:0]          wr_count,
  output logic [31:0]          err_count
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int QLW   = $clog2(QDEPTH) + 1;
  localparam int CNT_W = $clog2(LATENCY) + 1;
  localparam int LA_W  = 64 - LINE_SIZE_LOG2;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [QLW-1:0]   Q_FULL   = QLW'(QDEPTH);

  typedef logic [LINE_BITS-1:0] mem_t [MEM_LINES];

  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < MEM_LINES; i++) m[i] = {(LINE_BITS/32){32'(i)}};
    return m;
  endfunction

  // Power-up image only; reset never disturbs stored lines.
  mem_t mem_r = mem_init();

  resp_state_e          state_r, state_next_s;
  logic [CNT_W-1:0]     cnt_r, cnt_next_s;
  logic                 push_s, pop_s, exec_s;
  logic                 fifo_full_s, fifo_empty_s;
  logic [QLW-1:0]       fifo_level_s, level_next_s;
  l2_cmd_t              cmd_in_s, head_s;
  logic [IDX_W-1:0]     idx_s;
  logic                 err_s, is_read_s, is_write_s, mem_we_s;
  logic [LINE_BITS-1:0] resp_data_next_s;
  logic                 cmd_ready_r, resp_valid_r, resp_error_r;
  logic [LINE_BITS-1:0] resp_data_r;
  logic [31:0]          rd_count_r, wr_count_r, err_count_r;

  assign l2_cmd_ready      = cmd_ready_r;
  assign l2_response_valid = resp_valid_r;
  assign l2_response_data  = resp_data_r;
  assign l2_response_error = resp_error_r;
  assign rd_count          = rd_count_r;
  assign wr_count          = wr_count_r;
  assign err_count         = err_count_r;

  assign push_s   = l2_cmd_valid && cmd_ready_r && !fifo_full_s;
  assign cmd_in_s = '{cmd_type: l2_cmd_type, addr: l2_cmd_addr, data: l2_cmd_data,
                      size: l2_cmd_size, dirty: l2_cmd_dirty};

  tidc_sync_fifo #(.WIDTH($bits(l2_cmd_t)), .DEPTH(QDEPTH)) u_cmd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (cmd_in_s),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .level     (fifo_level_s),
    .head      (head_s)
  );

  // Ready is registered from the occupancy the queue will have after this edge.
  always_comb begin
    level_next_s = fifo_level_s;
    if (push_s && !pop_s) begin
      level_next_s = fifo_level_s + QLW'(1);
    end else if (!push_s && pop_s) begin
      level_next_s = fifo_level_s - QLW'(1);
    end else begin
      level_next_s = fifo_level_s;
    end
  end

  // Accept-side handshake register.
  always_ff @(posedge clk) begin
    if (rst) cmd_ready_r <= 1'b0;
    else     cmd_ready_r <= (level_next_s != Q_FULL);
  end

  // FSM state and latency counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_ZERO;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // FSM next state.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          state_next_s = ST_WAIT;
          cnt_next_s   = CNT_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == CNT_ZERO) state_next_s = ST_RESP;
        else                   cnt_next_s   = cnt_r - CNT_W'(1);
      end
      ST_RESP: begin
        if ((fifo_level_s > QLW'(1)) || push_s) begin
          state_next_s = ST_WAIT;
          cnt_next_s   = CNT_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = CNT_ZERO;
      end
    endcase
  end

  // FSM outputs: the head executes on the edge entering RESP and pops on the edge leaving it.
  always_comb begin
    exec_s = 1'b0;
    pop_s  = 1'b0;
    case (state_r)
      ST_WAIT: exec_s = (cnt_r == CNT_ZERO);
      ST_RESP: pop_s  = 1'b1;
      default: begin
        exec_s = 1'b0;
        pop_s  = 1'b0;
      end
    endcase
  end

  // Head-entry decode and error check.
  always_comb begin
    idx_s      = head_s.addr[LINE_SIZE_LOG2 +: IDX_W];
    err_s      = (head_s.addr[LINE_SIZE_LOG2-1:0] != {LINE_SIZE_LOG2{1'b0}}) ||
                 (head_s.addr[63:LINE_SIZE_LOG2] >= LA_W'(MEM_LINES)) ||
                 (head_s.size != 4'(LINE_SIZE_LOG2)) ||
                 !cmd_type_known(head_s.cmd_type);
    is_read_s  = (head_s.cmd_type == L2_CMD_READ);
    is_write_s = (head_s.cmd_type == L2_CMD_WRITE) ||
                 ((head_s.cmd_type == L2_CMD_WRITE_BACK) && head_s.dirty);
    mem_we_s   = exec_s && !err_s && is_write_s;
    if (err_s)           resp_data_next_s = {LINE_BITS{1'b0}};
    else if (is_write_s) resp_data_next_s = head_s.data;
    else                 resp_data_next_s = mem_r[idx_s];
  end

  // Response registers and completion counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_r <= 1'b0;
      resp_error_r <= 1'b0;
      resp_data_r  <= {LINE_BITS{1'b0}};
      rd_count_r   <= 32'd0;
      wr_count_r   <= 32'd0;
      err_count_r  <= 32'd0;
    end else begin
      resp_valid_r <= exec_s;
      if (exec_s) begin
        resp_data_r  <= resp_data_next_s;
        resp_error_r <= err_s;
        if (err_s)           err_count_r <= err_count_r + 32'd1;
        else if (is_write_s) wr_count_r  <= wr_count_r + 32'd1;
        else if (is_read_s)  rd_count_r  <= rd_count_r + 32'd1;
      end
    end
  end

  // Line memory write port.
  always_ff @(posedge clk) begin
    if (!rst && mem_we_s) mem_r[idx_s] <= head_s.data;
  end

endmodule
